// File: rtl/spio_aer_pkg.sv
// Shared definitions for the two-input SpiNNaker packet arbiter:
// packet width, port count and FSM state encoding.
package spio_aer_pkg;
  localparam int PKT_W  = 72;
  localparam int NPORTS = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DUMP = 1'b1
  } state_e;
endpackage

// File: rtl/spio_aer_pkt_arbiter_if.sv
// Bundles the two packet inputs, the merged output, the port enables and the status counters.
// The slave modport is the arbiter's view; the master modport is its environment's view.
interface spio_aer_pkt_arbiter_if #(
  parameter int CNT_BITS = 16
);
  import spio_aer_pkg::*;

  logic [NPORTS-1:0]   en;
  logic [PKT_W-1:0]    in0_data;
  logic                in0_vld;
  logic                in0_rdy;
  logic [PKT_W-1:0]    in1_data;
  logic                in1_vld;
  logic                in1_rdy;
  logic [PKT_W-1:0]    out_data;
  logic                out_vld;
  logic                out_rdy;
  logic                dump_mode;
  logic [CNT_BITS-1:0] fwd_cnt;
  logic [CNT_BITS-1:0] drop_cnt;

  modport slave (
    input  en, in0_data, in0_vld, in1_data, in1_vld, out_rdy,
    output in0_rdy, in1_rdy, out_data, out_vld, dump_mode, fwd_cnt, drop_cnt
  );

  modport master (
    output en, in0_data, in0_vld, in1_data, in1_vld, out_rdy,
    input  in0_rdy, in1_rdy, out_data, out_vld, dump_mode, fwd_cnt, drop_cnt
  );
endinterface

// File: rtl/spio_rr_arb2.sv
// Combinational two-way round-robin grant: on a tie the port that did not win last time wins.
module spio_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o,
  output logic       valid_o
);
  always_comb begin
    grant_idx_o = 1'b0;
    if (req_i == 2'b11) begin
      grant_idx_o = ~last_grant_i;
    end else if (req_i[1]) begin
      grant_idx_o = 1'b1;
    end
    valid_o = |req_i;
    grant_o = 2'b00;
    if (valid_o) begin
      grant_o = grant_idx_o ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: rtl/spio_aer_pkt_arbiter.sv
// Merges two SpiNNaker packet streams into one registered output stage, with per-port
// enables, saturating forward/drop counters and a stall watchdog that dumps input traffic.
module spio_aer_pkt_arbiter
  import spio_aer_pkg::*;
#(
  parameter int TIMEOUT  = 128,
  parameter int CNT_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  spio_aer_pkt_arbiter_if.slave  bus
);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic [PKT_W-1:0]    out_data_q, out_data_d;
  logic                out_vld_q, out_vld_d;
  logic                last_grant_q, last_grant_d;
  logic [7:0]          stall_q, stall_d;
  logic [CNT_BITS-1:0] fwd_q, fwd_d;
  logic [CNT_BITS-1:0] drop_q, drop_d;

  logic [NPORTS-1:0]   vld, rdy, cand, drop;
  logic [PKT_W-1:0]    win_data;
  logic [1:0]          grant;
  logic                grant_idx, grant_vld;
  logic                load, dumping;
  logic [1:0]          drop_inc;
  logic [CNT_BITS:0]   drop_sum;

  assign vld  = {bus.in1_vld, bus.in0_vld};
  assign cand = vld & bus.en;
  assign load = !out_vld_q || bus.out_rdy;

  spio_rr_arb2 u_arb (
    .req_i        (cand),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .valid_o      (grant_vld)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A link that frees up in the very cycle the timeout is hit is not dumped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (stall_q == TIMEOUT_C && !bus.out_rdy) state_d = ST_DUMP;
      ST_DUMP: if (bus.out_rdy) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM: outputs. Disabled ports and every port in DUMP are drained unconditionally.
  always_comb begin
    dumping = (state_q == ST_DUMP);
    rdy     = '0;
    for (int n = 0; n < NPORTS; n++) begin
      rdy[n] = dumping || !bus.en[n] || (load && grant[n]);
    end
  end

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_drop
      assign drop[gi] = vld[gi] && rdy[gi] && (dumping || !bus.en[gi]);
    end
  endgenerate

  assign drop_inc = {1'b0, drop[0]} + {1'b0, drop[1]};
  assign drop_sum = {1'b0, drop_q} + {{(CNT_BITS-1){1'b0}}, drop_inc};
  assign win_data = grant_idx ? bus.in1_data : bus.in0_data;

  always_comb begin
    out_data_d   = out_data_q;
    out_vld_d    = out_vld_q;
    last_grant_d = last_grant_q;
    fwd_d        = fwd_q;
    if (dumping) begin
      if (bus.out_rdy) out_vld_d = 1'b0;
    end else if (load) begin
      out_vld_d = grant_vld;
      if (grant_vld) begin
        out_data_d   = win_data;
        last_grant_d = grant_idx;
        if (fwd_q != '1) fwd_d = fwd_q + 1'b1;
      end
    end

    drop_d = drop_sum[CNT_BITS] ? '1 : drop_sum[CNT_BITS-1:0];

    stall_d = stall_q;
    if (!out_vld_q || bus.out_rdy) begin
      stall_d = '0;
    end else if (stall_q != TIMEOUT_C) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_vld_q    <= 1'b0;
      last_grant_q <= 1'b1;
      stall_q      <= '0;
      fwd_q        <= '0;
      drop_q       <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_vld_q    <= out_vld_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
      fwd_q        <= fwd_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.in0_rdy   = rdy[0];
  assign bus.in1_rdy   = rdy[1];
  assign bus.out_data  = out_data_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.dump_mode = (state_q == ST_DUMP);
  assign bus.fwd_cnt   = fwd_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_spio_aer_pkt_arbiter.sv
// Directed-vector bench for the two-input packet arbiter, built with 4-bit counters
// so that saturation is reachable in a short run.
module tb_spio_aer_pkt_arbiter;
  localparam int CB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  spio_aer_pkt_arbiter_if #(.CNT_BITS(CB)) bus ();

  spio_aer_pkt_arbiter #(.TIMEOUT(128), .CNT_BITS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got still-running required finished");
    $fatal(1, "time limit");
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 2'b11;
    bus.in0_data = '0; bus.in0_vld = 1'b0;
    bus.in1_data = '0; bus.in1_vld = 1'b0;
    bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %0b want 0", bus.out_vld); end
    checks++; if (bus.out_data !== 72'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    checks++; if (bus.dump_mode !== 1'b0) begin errors++; $display("FAIL reset_dump got %0b want 0", bus.dump_mode); end
    checks++; if (bus.fwd_cnt !== 4'd0) begin errors++; $display("FAIL reset_fwd got %0d want 0", bus.fwd_cnt); end
    checks++; if (bus.drop_cnt !== 4'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", bus.drop_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [71:0] a;
    a = 72'hA5_0123_4567_89AB_CDEF;
    do_reset();
    bus.in0_data = a; bus.in0_vld = 1'b1; bus.out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (bus.in0_rdy !== 1'b1) begin errors++; $display("FAIL single_in0_rdy got %0b want 1", bus.in0_rdy); end
    checks++; if (bus.in1_rdy !== 1'b0) begin errors++; $display("FAIL single_in1_rdy got %0b want 0", bus.in1_rdy); end
    @(posedge clk); #1 bus.in0_vld = 1'b0;
    checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL single_out_vld got %0b want 1", bus.out_vld); end
    checks++; if (bus.out_data !== a) begin errors++; $display("FAIL single_out_data got %h want %h", bus.out_data, a); end
    checks++; if (bus.fwd_cnt !== 4'd1) begin errors++; $display("FAIL single_fwd got %0d want 1", bus.fwd_cnt); end
    @(posedge clk); #1;
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", bus.out_vld); end
    $display("test_single: packet %h forwarded", a);
  endtask

  task automatic test_back_to_back();
    logic [71:0] b0, b1, want;
    int i0, i1, w;
    b0 = 72'h10_0000_0000_0000_0000;
    b1 = 72'h20_0000_0000_0000_0000;
    i0 = 0; i1 = 0;
    do_reset();
    bus.out_rdy = 1'b1;
    bus.in0_vld = 1'b1; bus.in1_vld = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.in0_data = b0 + 72'(i0);
      bus.in1_data = b1 + 72'(i1);
      w = (c % 2 == 0) ? 0 : 1;
      want = (w == 0) ? b0 + 72'(i0) : b1 + 72'(i1);
      @(negedge clk);
      checks++; if (bus.in0_rdy !== (w == 0)) begin errors++; $display("FAIL b2b_in0_rdy[%0d] got %0b want %0b", c, bus.in0_rdy, w == 0); end
      checks++; if (bus.in1_rdy !== (w == 1)) begin errors++; $display("FAIL b2b_in1_rdy[%0d] got %0b want %0b", c, bus.in1_rdy, w == 1); end
      @(posedge clk); #1;
      checks++; if (bus.out_data !== want) begin errors++; $display("FAIL b2b_out[%0d] got %h want %h", c, bus.out_data, want); end
      if (w == 0) i0++; else i1++;
      $display("test_back_to_back: cycle %0d port %0d data %h", c, w, bus.out_data);
    end
    bus.in0_vld = 1'b0; bus.in1_vld = 1'b0;
    checks++; if (bus.fwd_cnt !== 4'd6) begin errors++; $display("FAIL b2b_fwd got %0d want 6", bus.fwd_cnt); end
  endtask

  task automatic test_dump();
    logic [71:0] x1, x9;
    x1 = 72'hC1_1111_1111_1111_1111;
    x9 = 72'hC9_9999_9999_9999_9999;
    do_reset();
    bus.in0_data = x1; bus.in0_vld = 1'b1; bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    bus.out_rdy = 1'b0;
    bus.in0_data = 72'hC2_0000_0000_0000_0000;
    for (int k = 1; k <= 129; k++) begin
      @(posedge clk); #1;
      if (k == 128) begin
        checks++; if (bus.dump_mode !== 1'b0) begin errors++; $display("FAIL dump_early got %0b want 0", bus.dump_mode); end
        checks++; if (bus.in0_rdy !== 1'b0) begin errors++; $display("FAIL dump_blocked_rdy got %0b want 0", bus.in0_rdy); end
      end
    end
    checks++; if (bus.dump_mode !== 1'b1) begin errors++; $display("FAIL dump_enter got %0b want 1", bus.dump_mode); end
    checks++; if (bus.in0_rdy !== 1'b1) begin errors++; $display("FAIL dump_in0_rdy got %0b want 1", bus.in0_rdy); end
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      bus.in0_data = 72'hC3_0000_0000_0000_0000 + 72'(j);
    end
    checks++; if (bus.drop_cnt !== 4'd10) begin errors++; $display("FAIL dump_drop got %0d want 10", bus.drop_cnt); end
    checks++; if (bus.out_data !== x1) begin errors++; $display("FAIL dump_held_data got %h want %h", bus.out_data, x1); end
    checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL dump_held_vld got %0b want 1", bus.out_vld); end
    checks++; if (bus.fwd_cnt !== 4'd1) begin errors++; $display("FAIL dump_fwd got %0d want 1", bus.fwd_cnt); end
    bus.in0_vld = 1'b0; bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.dump_mode !== 1'b0) begin errors++; $display("FAIL dump_exit got %0b want 0", bus.dump_mode); end
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL dump_exit_vld got %0b want 0", bus.out_vld); end
    checks++; if (bus.drop_cnt !== 4'd10) begin errors++; $display("FAIL dump_exit_drop got %0d want 10", bus.drop_cnt); end
    bus.in0_data = x9; bus.in0_vld = 1'b1;
    @(negedge clk);
    checks++; if (bus.in0_rdy !== 1'b1) begin errors++; $display("FAIL resume_rdy got %0b want 1", bus.in0_rdy); end
    @(posedge clk); #1 bus.in0_vld = 1'b0;
    checks++; if (bus.out_data !== x9) begin errors++; $display("FAIL resume_data got %h want %h", bus.out_data, x9); end
    checks++; if (bus.fwd_cnt !== 4'd2) begin errors++; $display("FAIL resume_fwd got %0d want 2", bus.fwd_cnt); end
    $display("test_dump: drop=%0d fwd=%0d", bus.drop_cnt, bus.fwd_cnt);
  endtask

  task automatic test_disabled();
    logic [71:0] want;
    do_reset();
    bus.en = 2'b10; bus.out_rdy = 1'b1;
    bus.in0_vld = 1'b1; bus.in1_vld = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.in0_data = 72'hB0_0000_0000_0000_0000 + 72'(j);
      bus.in1_data = 72'hD0_0000_0000_0000_0000 + 72'(j);
      want = 72'hD0_0000_0000_0000_0000 + 72'(j);
      @(negedge clk);
      checks++; if (bus.in0_rdy !== 1'b1) begin errors++; $display("FAIL dis_in0_rdy[%0d] got %0b want 1", j, bus.in0_rdy); end
      checks++; if (bus.in1_rdy !== 1'b1) begin errors++; $display("FAIL dis_in1_rdy[%0d] got %0b want 1", j, bus.in1_rdy); end
      @(posedge clk); #1;
      checks++; if (bus.out_data !== want) begin errors++; $display("FAIL dis_out[%0d] got %h want %h", j, bus.out_data, want); end
      checks++; if (bus.drop_cnt !== 4'(j + 1)) begin errors++; $display("FAIL dis_drop[%0d] got %0d want %0d", j, bus.drop_cnt, j + 1); end
      $display("test_disabled: cycle %0d out %h drop %0d", j, bus.out_data, bus.drop_cnt);
    end
    bus.in0_vld = 1'b0; bus.in1_vld = 1'b0;
    checks++; if (bus.fwd_cnt !== 4'd4) begin errors++; $display("FAIL dis_fwd got %0d want 4", bus.fwd_cnt); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    bus.en = 2'b00; bus.out_rdy = 1'b0;
    bus.in0_vld = 1'b1; bus.in1_vld = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      bus.in0_data = 72'(j); bus.in1_data = 72'(j + 100);
      @(posedge clk); #1;
      if (j == 7) begin
        checks++; if (bus.drop_cnt !== 4'd14) begin errors++; $display("FAIL dropsat_14 got %0d want 14", bus.drop_cnt); end
      end
      if (j >= 8) begin
        checks++; if (bus.drop_cnt !== 4'd15) begin errors++; $display("FAIL dropsat_15[%0d] got %0d want 15", j, bus.drop_cnt); end
      end
    end
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL dropsat_out_vld got %0b want 0", bus.out_vld); end
    bus.in0_vld = 1'b0; bus.in1_vld = 1'b0; bus.en = 2'b11;
    $display("test_drop_saturate: drop=%0d", bus.drop_cnt);
  endtask

  task automatic test_fwd_saturate_and_reset();
    logic [71:0] last;
    do_reset();
    bus.en = 2'b01; bus.out_rdy = 1'b1; bus.in0_vld = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.in0_data = 72'hE0_0000_0000_0000_0000 + 72'(j);
      @(posedge clk); #1;
      if (j == 14) begin
        checks++; if (bus.fwd_cnt !== 4'd15) begin errors++; $display("FAIL fwdsat_15 got %0d want 15", bus.fwd_cnt); end
      end
    end
    last = 72'hE0_0000_0000_0000_0013;
    checks++; if (bus.fwd_cnt !== 4'd15) begin errors++; $display("FAIL fwdsat_stick got %0d want 15", bus.fwd_cnt); end
    checks++; if (bus.out_data !== last) begin errors++; $display("FAIL fwdsat_data got %h want %h", bus.out_data, last); end
    bus.in0_data = 72'hEF_0000_0000_0000_0000;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL arst_out_vld got %0b want 0", bus.out_vld); end
    checks++; if (bus.out_data !== 72'h0) begin errors++; $display("FAIL arst_out_data got %h want 0", bus.out_data); end
    checks++; if (bus.fwd_cnt !== 4'd0) begin errors++; $display("FAIL arst_fwd got %0d want 0", bus.fwd_cnt); end
    checks++; if (bus.drop_cnt !== 4'd0) begin errors++; $display("FAIL arst_drop got %0d want 0", bus.drop_cnt); end
    checks++; if (bus.dump_mode !== 1'b0) begin errors++; $display("FAIL arst_dump got %0b want 0", bus.dump_mode); end
    #1 rst = 1'b0;
    bus.in0_vld = 1'b0;
    $display("test_fwd_saturate_and_reset: counters cleared by async reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_dump();
    test_disabled();
    test_drop_saturate();
    test_fwd_saturate_and_reset();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spio_aer_pkt_arbiter.md
# spio_aer_pkt_arbiter

Two-input round-robin arbiter that merges SpiNNaker packet streams from two AER-to-SpiNNaker mappers (for example, a retina and a cochlea) onto a single SpiNNaker packet interface. It sits between the mappers' packet outputs and the link driver. It contains a one-entry registered output stage, per-port enables, and a stall watchdog. The watchdog discards incoming packets while the downstream link stays blocked, so upstream AER handshakes never lock up.

## Interface
Parameters:
- TIMEOUT, 128: consecutive blocked output cycles before entering dump mode; legal range 1..255.
- CNT_BITS, 16: width of the forwarded and dropped packet counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  2  per-port enable; bit n = port n. A disabled port is drained: rdy=1, packets discarded and counted as dropped.
- in0_data  in  72  port 0 packet
- in0_vld  in  1  port 0 valid
- in0_rdy  out  1  port 0 ready (combinational)
- in1_data  in  72  port 1 packet
- in1_vld  in  1  port 1 valid
- in1_rdy  out  1  port 1 ready (combinational)
- out_data  out  72  merged packet (registered)
- out_vld  out  1  merged valid (registered)
- out_rdy  in  1  downstream ready
- dump_mode  out  1  high while in state DUMP (registered)
- fwd_cnt  out  CNT_BITS  packets forwarded to output; saturating
- drop_cnt  out  CNT_BITS  packets discarded, from dump or disabled ports; saturating

## Operation
- Handshake rules, all ports:
  - Transfer occurs on a clock edge where vld && rdy.
  - A producer holds vld and data stable until the transfer.
  - out_vld never drops before a transfer, including in DUMP.
- load = !out_vld || out_rdy; the output register can take a packet this cycle.
- A candidate port is one with vld && en.
- State RUN:
  - With one candidate, that port wins.
  - With two candidates, the port ≠ last_grant wins.
  - If load is high: winner rdy = 1, out_data <= winner data, out_vld <= 1, last_grant <= winner, fwd_cnt increments.
  - If load is low: enabled ports rdy = 0.
  - Disabled ports always have rdy = 1. Each transfer on a disabled port increments drop_cnt.
- Output drain: an out_vld && out_rdy edge with no new load clears out_vld.
- Stall counter stall_ctr (8 bits):
  - Clears when !out_vld || out_rdy.
  - Otherwise increments, saturating at TIMEOUT.
- RUN -> DUMP when stall_ctr == TIMEOUT.
- State DUMP:
  - in0_rdy = in1_rdy = 1. All input transfers are discarded and each increments drop_cnt.
  - The output register is held unchanged.
- DUMP -> RUN on the first cycle out_rdy = 1. The held packet transfers on that edge, and arbitration resumes the next cycle.
- Counter increments:
  - If both ports drop in the same cycle, drop_cnt increments by 2, saturating at all-ones.
  - Counters never wrap.
- en changing mid-stream has no effect on a packet already in the output register.

## Timing
- Latency is 1 cycle from input transfer to out_vld high with that data.
- Full throughput: one packet per cycle while out_rdy = 1, alternating between ports when both are valid.
- Reset values: out_vld 0, out_data 0, dump_mode 0, fwd_cnt 0, drop_cnt 0, state RUN, stall_ctr 0, last_grant 1 (so port 0 wins the first tie).
- dump_mode rises 1 cycle after stall_ctr reaches TIMEOUT, i.e. on the edge that enters DUMP. It falls on the edge that leaves DUMP.
- Reset asserted mid-packet: the output packet is lost, and the counters and state return to reset values immediately (asynchronous).
- Simultaneous drain and load: the new packet replaces the draining one with no bubble.

## Structure
- Shared package spio_aer_pkg: packet width constant (72), state encoding (RUN, DUMP), port count (2).
- One natural sub-module, spio_rr_arb2: a combinational two-way round-robin grant with a last_grant input and grant/valid outputs.
- Counters and FSM live in the top module.

## Test plan
- Reset, then in0_vld=1 (data A), out_rdy=1 → in0_rdy=1; cycle later out_vld=1, out_data=A; fwd_cnt=1.
- Both ports valid continuously, out_rdy=1, 6 cycles → output order P0,P1,P0,P1,P0,P1; each rdy asserted every other cycle; fwd_cnt=6.
- out_vld=1, out_rdy held 0 for 128 cycles with in0 valid → dump_mode=1 on cycle 129; in0_rdy=1 thereafter; 10 packets → drop_cnt=10, out_data unchanged.
- From DUMP, raise out_rdy → held packet transfers, dump_mode=0 next cycle, next in0 packet forwarded; stall_ctr=0.
- en=2'b10, both valid → in0_rdy=1 every cycle, drop_cnt counts port 0 packets; only port 1 data appears on out_data.
- Preload fwd_cnt near max (CNT_BITS=4), send 20 packets → fwd_cnt sticks at 15; assert rst mid-transfer → out_vld=0 and counters 0 immediately.
